// File: rtl/seq_pattern_generator.sv
// -----------------------------------------------------------------------------
// seq_pattern_generator
//
// Serial pattern transmitter. On an accepted start it sends a PAT_W-bit
// pattern, most significant bit first, one bit per clock. The pattern is sent
// rep_count times. Between repetitions the output idles at zero for GAP_CYC
// cycles. A one-cycle done pulse closes each transmission.
//
// Ports
//   clock      in   1      system clock, rising edge
//   reset      in   1      synchronous reset, active low
//   start      in   1      request a transmission (only looked at in IDLE)
//   pattern    in   PAT_W  pattern to send, captured when start is accepted
//   rep_count  in   CNT_W  number of repetitions, captured with start
//   seq_out    out  1      serial data bit (registered)
//   seq_valid  out  1      seq_out carries a pattern bit this cycle
//   busy       out  1      transmission in progress (SHIFT/GAP/DONE)
//   done       out  1      one-cycle completion pulse
// -----------------------------------------------------------------------------
module seq_pattern_generator #(
    parameter int PAT_W   = 3,
    parameter int CNT_W   = 4,
    parameter int GAP_CYC = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] rep_count,
    output logic             seq_out,
    output logic             seq_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    // The gap counter only has to hold GAP_CYC-1.
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_TOP = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [PAT_W-1:0]   pat_reg, pat_next;
    logic [CNT_W-1:0]   reps_reg, reps_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;

    logic               seq_out_reg, seq_out_next;
    logic               seq_valid_reg, seq_valid_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= IDLE;
            pat_reg       <= '0;
            reps_reg      <= '0;
            idx_reg       <= '0;
            gap_reg       <= '0;
            seq_out_reg   <= 1'b0;
            seq_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pat_reg       <= pat_next;
            reps_reg      <= reps_next;
            idx_reg       <= idx_next;
            gap_reg       <= gap_next;
            seq_out_reg   <= seq_out_next;
            seq_valid_reg <= seq_valid_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next = state_reg;
        pat_next   = pat_reg;
        reps_next  = reps_reg;
        idx_next   = idx_reg;
        gap_next   = gap_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (rep_count != '0) begin
                        state_next = SHIFT;
                        pat_next   = pattern;
                        reps_next  = rep_count;
                        idx_next   = IDX_TOP;
                    end else begin
                        // Zero repetitions: go straight to the done pulse.
                        state_next = DONE;
                    end
                end
            end

            SHIFT: begin
                if (idx_reg == '0) begin
                    // Last bit of this repetition; count it off, never wrapping.
                    if (reps_reg != '0) begin
                        reps_next = reps_reg - CNT_ONE;
                    end
                    if (reps_reg > CNT_ONE) begin
                        idx_next = IDX_TOP;
                        if (GAP_CYC > 0) begin
                            state_next = GAP;
                            gap_next   = GAP_TOP;
                        end
                        // With no gap we stay in SHIFT and restart at the MSB.
                    end else begin
                        state_next = DONE;
                    end
                end else begin
                    idx_next = idx_reg - 1'b1;
                end
            end

            GAP: begin
                if (gap_reg == '0) begin
                    state_next = SHIFT;
                end else begin
                    gap_next = gap_reg - 1'b1;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are registered from the values the state will hold next
        // cycle, so they line up with the state without any input-to-output
        // combinational path.
        seq_valid_next = (state_next == SHIFT);
        seq_out_next   = (state_next == SHIFT) & pat_next[idx_next];
        busy_next      = (state_next != IDLE);
        done_next      = (state_next == DONE);
    end

    assign seq_out   = seq_out_reg;
    assign seq_valid = seq_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule
